rv_instr_encoder: RTL

Sequential RV32I instruction encoder and program writer. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit machine words. Supported opcodes: lw, sw, R-type, beq, I-type ALU and jal. Each legal word is written to consecutive instruction-memory addresses through a back-pressured write port. Bench and boot-loader logic use it to build programs that the core's control decoder then consumes.

---
 rtl/rv_instr_encoder.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder: packs decoded field bundles into machine words and
// writes them to consecutive instruction-memory addresses through a one-stage output register.
module rv_instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_f7b5,
    input  logic [31:0]       in_imm,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [2:0] FMT_LOAD   = 3'd0;
    localparam logic [2:0] FMT_STORE  = 3'd1;
    localparam logic [2:0] FMT_R      = 3'd2;
    localparam logic [2:0] FMT_BRANCH = 3'd3;
    localparam logic [2:0] FMT_IALU   = 3'd4;
    localparam logic [2:0] FMT_JAL    = 3'd5;

    logic signed [31:0] imm;
    logic               is_shift;
    logic [6:0]         funct7;
    logic [31:0]        word;
    logic signed [31:0] lo;
    logic signed [31:0] hi;
    logic               need_even;
    logic [1:0]         code;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W:0]    count_inc;
    logic               accept;

    assign imm       = in_imm;
    assign is_shift  = (in_fmt == FMT_IALU) && (in_funct3[1:0] == 2'b01);
    assign funct7    = {1'b0, in_f7b5, 5'b00000};
    assign in_ready  = !reset && !clear && !full && (!mem_valid || mem_ready);
    assign accept    = in_valid && in_ready;
    assign count_inc = count + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        word = '0;
        case (in_fmt)
            FMT_LOAD:   word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            FMT_STORE:  word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            FMT_R:      word = {funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            FMT_BRANCH: word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], 7'b1100011};
            FMT_IALU:   word = is_shift ? {funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'b0010011}
                                        : {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            FMT_JAL:    word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            default:    word = '0;
        endcase
    end

    // Range is judged before alignment so an odd, out-of-range offset reports code 3.
    always_comb begin
        lo        = -32'sd2048;
        hi        = 32'sd2047;
        need_even = 1'b0;
        code      = 2'd0;
        if (is_shift) begin
            lo = 32'sd0;
            hi = 32'sd31;
        end else if (in_fmt == FMT_BRANCH) begin
            lo        = -32'sd4096;
            hi        = 32'sd4094;
            need_even = 1'b1;
        end else if (in_fmt == FMT_JAL) begin
            lo        = -32'sh0010_0000;
            hi        = 32'sh000F_FFFE;
            need_even = 1'b1;
        end
        if (in_fmt > FMT_JAL)
            code = 2'd1;
        else if (in_fmt != FMT_R && (imm < lo || imm > hi))
            code = 2'd3;
        else if (need_even && in_imm[0])
            code = 2'd2;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            if (mem_valid && mem_ready)
                mem_valid <= 1'b0;
            if (clear) begin
                wr_ptr   <= '0;
                count    <= '0;
                full     <= 1'b0;
                err      <= 1'b0;
                err_code <= 2'd0;
            end else if (accept) begin
                if (code != 2'd0) begin
                    err <= 1'b1;
                    if (!err)
                        err_code <= code;
                end else begin
                    mem_valid <= 1'b1;
                    mem_addr  <= wr_ptr;
                    mem_wdata <= word;
                    wr_ptr    <= wr_ptr + ADDR_W'(1);
                    count     <= count_inc;
                    full      <= count_inc[ADDR_W];
                end
            end
        end
    end

endmodule
